// File: rtl/req_priority_arbiter.sv
// req_priority_arbiter: 8-way arbiter. A grant is held until done, withdrawal or hold timeout.
// Define ROUND_ROBIN_EN for rotating priority; the default build uses fixed highest-index priority.
module req_priority_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST  = TIMEOUT_EN ? 8'(MAX_HOLD - 1) : 8'd0;

    state_t     state;
    logic [7:0] hold_cnt;
    logic [7:0] mask;
    logic [7:0] cand;
    logic [2:0] ptr;
    logic [2:0] winner;
    logic       cand_any;
    logic       owner_req;
    logic       hold_expired;
    logic       release_now;

    assign cand         = req & ~mask;
    assign cand_any     = |cand;
    assign owner_req    = req[gnt_idx];
    assign hold_expired = TIMEOUT_EN && (hold_cnt == HOLD_LAST);
    assign release_now  = done || !owner_req || hold_expired;

`ifdef ROUND_ROBIN_EN
    // Scan runs far-to-near from ptr-1 downward, so the nearest candidate is written last and wins.
    always_comb begin
        winner = 3'd0;
        for (int k = N; k >= 1; k--) begin
            if (cand[ptr - 3'(k)]) begin
                winner = ptr - 3'(k);
            end
        end
    end
`else
    // ptr is tracked for the rotating build only; fixed priority ignores it.
    logic ptr_unused;
    assign ptr_unused = ^ptr;

    always_comb begin
        winner = 3'd0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                winner = 3'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_idx  <= '0;
            gnt_vld  <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            ptr      <= '0;
            mask     <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    mask <= '0;
                    if (cand_any) begin
                        state    <= BUSY;
                        gnt      <= 8'd1 << winner;
                        gnt_idx  <= winner;
                        gnt_vld  <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        gnt_vld <= 1'b0;
                        ptr     <= gnt_idx;
                        // Only a pure hold-limit release pulses timeout and masks the owner once.
                        if (!done && owner_req) begin
                            timeout <= 1'b1;
                            mask    <= 8'd1 << gnt_idx;
                        end
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_priority_arbiter.sv
// tb_req_priority_arbiter: directed and randomized checks of req_priority_arbiter against a
// behavioural model. Honours ROUND_ROBIN_EN the same way the design does.
module tb_req_priority_arbiter;

    localparam int MAX_HOLD_TB = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: who owns the grant, how many cycles it has been visible, who is locked out.
    int m_busy;
    int m_owner;
    int m_hold;
    int m_ptr;
    int m_mask_id;
    int m_tmo;
    int m_win;
    logic [7:0] m_cand;

    req_priority_arbiter #(
        .N(8),
        .MAX_HOLD(MAX_HOLD_TB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .done(done),
        .gnt(gnt),
        .gnt_idx(gnt_idx),
        .gnt_vld(gnt_vld),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] c, input int p);
`ifdef ROUND_ROBIN_EN
        for (int off = 1; off <= 8; off++) begin
            int i;
            i = (p - off + 8) % 8;
            if (c[i]) return i;
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (c[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Behavioural reference, advanced on the same edges the design sees.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy    = 0;
            m_owner   = 0;
            m_hold    = 0;
            m_ptr     = 0;
            m_mask_id = -1;
            m_tmo     = 0;
        end else if (m_busy == 0) begin
            m_tmo  = 0;
            m_cand = req;
            if (m_mask_id >= 0) m_cand[m_mask_id] = 1'b0;
            m_mask_id = -1;
            m_win = pick(m_cand, m_ptr);
            if (m_win >= 0) begin
                m_busy  = 1;
                m_owner = m_win;
                m_hold  = 1;
            end
        end else begin
            m_tmo = 0;
            if (done || !req[m_owner]) begin
                m_busy = 0;
                m_ptr  = m_owner;
            end else if (MAX_HOLD_TB != 0 && m_hold == MAX_HOLD_TB) begin
                m_busy    = 0;
                m_ptr     = m_owner;
                m_tmo     = 1;
                m_mask_id = m_owner;
            end else begin
                m_hold++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        checkOutput("gnt", int'(gnt), m_busy ? (1 << m_owner) : 0);
        checkOutput("gnt_idx", int'(gnt_idx), m_owner);
        checkOutput("gnt_vld", int'(gnt_vld), m_busy);
        checkOutput("timeout", int'(timeout), m_tmo);
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(8'h00, 1'b0);
        repeat (2) step();
        checkOutput("rst_gnt", int'(gnt), 0);
        checkOutput("rst_idx", int'(gnt_idx), 0);
        checkOutput("rst_vld", int'(gnt_vld), 0);
        checkOutput("rst_tmo", int'(timeout), 0);

        // First grant goes to the highest requester 5.
        rst_n = 1'b1;
        applyStimulus(8'b0010_0100, 1'b0);
        step();
        checkOutput("first_gnt", int'(gnt), 8'h20);
        checkOutput("first_idx", int'(gnt_idx), 5);
        checkOutput("first_vld", int'(gnt_vld), 1);
        checkOutput("first_tmo", int'(timeout), 0);
        checkOutput("model_first_idx", m_owner, 5);

        applyStimulus(8'b0010_0100, 1'b1);
        step();
        checkOutput("done_gap_vld", int'(gnt_vld), 0);
        checkOutput("done_gap_gnt", int'(gnt), 0);
        applyStimulus(8'b0010_0100, 1'b0);
        step();
        checkOutput("regrant_vld", int'(gnt_vld), 1);
`ifdef ROUND_ROBIN_EN
        checkOutput("regrant_idx", int'(gnt_idx), 2);
`else
        checkOutput("regrant_idx", int'(gnt_idx), 5);
`endif

        // Hold limit: 7 held for MAX_HOLD cycles, then timeout and 0 wins.
        rst_n = 1'b0;
        applyStimulus(8'b1000_0001, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < MAX_HOLD_TB; i++) begin
            checkOutput("hold_vld", int'(gnt_vld), 1);
            checkOutput("hold_idx", int'(gnt_idx), 7);
            checkOutput("hold_tmo", int'(timeout), 0);
            step();
        end
        checkOutput("tmo_pulse", int'(timeout), 1);
        checkOutput("tmo_vld", int'(gnt_vld), 0);
        checkOutput("model_tmo", m_tmo, 1);
        step();
        checkOutput("after_tmo_idx", int'(gnt_idx), 0);
        checkOutput("after_tmo_vld", int'(gnt_vld), 1);
        checkOutput("after_tmo_tmo", int'(timeout), 0);

        // Owner 3 withdraws its request.
        rst_n = 1'b0;
        applyStimulus(8'b0000_1000, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("own3_idx", int'(gnt_idx), 3);
        applyStimulus(8'h00, 1'b0);
        step();
        checkOutput("withdraw_vld", int'(gnt_vld), 0);
        checkOutput("withdraw_tmo", int'(timeout), 0);
        step();
        checkOutput("idle_gnt", int'(gnt), 0);

        // done coincides with the last allowed hold cycle: normal release, no lockout.
        applyStimulus(8'b0000_1000, 1'b0);
        step();
        checkOutput("lim_start_vld", int'(gnt_vld), 1);
        repeat (MAX_HOLD_TB - 1) step();
        checkOutput("lim_last_vld", int'(gnt_vld), 1);
        applyStimulus(8'b0000_1000, 1'b1);
        step();
        checkOutput("lim_rel_vld", int'(gnt_vld), 0);
        checkOutput("lim_rel_tmo", int'(timeout), 0);
        applyStimulus(8'b0000_1000, 1'b0);
        step();
        checkOutput("lim_regrant_vld", int'(gnt_vld), 1);
        checkOutput("lim_regrant_idx", int'(gnt_idx), 3);

        // Asynchronous reset in the middle of a grant to 6.
        applyStimulus(8'b0100_0000, 1'b0);
        step();
        step();
        checkOutput("pre_rst_idx", int'(gnt_idx), 6);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_gnt", int'(gnt), 0);
        checkOutput("async_vld", int'(gnt_vld), 0);
        checkOutput("async_idx", int'(gnt_idx), 0);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("post_rst_idx", int'(gnt_idx), 6);
        checkOutput("post_rst_vld", int'(gnt_vld), 1);

        // Randomized traffic; the per-cycle compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            int r;
            logic [7:0] nr;
            nr = req;
            r = int'($urandom_range(0, 9));
            if (r < 2) nr = 8'($urandom);
            else if (r == 2) nr = 8'h00;
            else if (r == 3) nr[$urandom_range(0, 7)] = ~nr[$urandom_range(0, 7)];
            applyStimulus(nr, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            step();
        end

        step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/req_priority_arbiter.md
Name: req_priority_arbiter

Overview:
- Sequential arbiter sharing one resource among 8 requesters.
- Uses the highest-set-bit priority-encoder rule (index 7 highest) to select a winner.
- Holds the grant until the owner releases it, withdraws its request, or exceeds a hold limit.
- Sits between requesting agents and the shared datapath; drives both the one-hot grant and the encoded grant index.

Parameters:
- N, 8, number of requesters; fixed at 8 for this revision, with index width 3.
- MAX_HOLD, 15, maximum consecutive grant cycles before a forced release; 0 disables the timeout; legal range 0..255.

Ports:
- clk      input   1  system clock, rising edge
- rst_n    input   1  asynchronous active-low reset
- req      input   8  request vector; bit i is requester i
- done     input   1  owner releases grant; sampled only while gnt_vld=1
- gnt      output  8  one-hot grant, registered
- gnt_idx  output  3  encoded index of the granted requester, registered
- gnt_vld  output  1  a grant is active
- timeout  output  1  one-cycle pulse on a forced release

Behaviour:
- Reset (async, rst_n=0):
  - gnt=0, gnt_idx=0, gnt_vld=0, timeout=0.
  - hold counter=0, rr pointer ptr=0, mask=0, state=IDLE.
  - Reset mid-grant drops the grant immediately; no timeout pulse is generated.
- States:
  - IDLE: no grant active.
  - BUSY: gnt_vld=1.
- IDLE, winner selection:
  - Candidate vector is req & ~mask.
  - If the candidate vector is nonzero, the winner is chosen per the arbitration rule.
  - Next edge: gnt=1<<winner, gnt_idx=winner, gnt_vld=1, counter=0, mask cleared, state=BUSY.
  - Latency is 1 cycle from req seen to grant visible.
  - If the candidate vector is zero, remain in IDLE and clear mask.
- BUSY, release conditions evaluated each cycle in this priority order:
  - (a) done=1.
  - (b) req[gnt_idx]=0 (requester withdrew).
  - (c) MAX_HOLD!=0 and counter==MAX_HOLD-1.
- BUSY, on any release:
  - Next edge: gnt=0, gnt_vld=0, state=IDLE, ptr=gnt_idx.
  - gnt_idx keeps its last value.
  - At least one idle cycle always separates consecutive grants.
- Timeout (release via (c) only):
  - timeout=1 for exactly the cycle after the release edge, coincident with gnt_vld=0.
  - mask=1<<gnt_idx for the next arbitration only, so a timed-out requester cannot be re-granted immediately.
  - If it is the only requester, it is re-granted one arbitration later, after mask clears.
- done together with counter==MAX_HOLD-1: treated as a normal release; no timeout pulse, no mask.
- Otherwise in BUSY: counter increments, saturating at 255.
  - Other req bits are ignored; there is no preemption.
- done while IDLE: ignored.
- req bits may change at any time; only the value sampled at the arbitration edge matters.

Arbitration rule:
- Default is fixed priority: the highest set index among candidates wins.
- With ROUND_ROBIN_EN defined, the rotating rule below applies instead.

Optional Feature:
- Macro: ROUND_ROBIN_EN.
- Defined (rotating priority):
  - Scan starts at ptr-1 and proceeds downward modulo 8: ptr-1, ptr-2, …, ptr.
  - The first candidate found wins.
  - After reset ptr=0, so the first arbitration matches fixed priority (7 first).
  - The most recent owner becomes lowest priority.
- Undefined:
  - Fixed highest-index priority.
  - ptr is still maintained but not used for selection; starvation of low indices is possible.

Test Plan:
- Reset, then req=8'b0010_0100 held → gnt=8'b0010_0000, gnt_idx=5, gnt_vld=1 one cycle after req sampled; timeout=0.
- Owner 5 asserts done one cycle, req=8'b0010_0100 held:
  - Fixed build: gap cycle with gnt_vld=0, then gnt_idx=5 again.
  - ROUND_ROBIN_EN build: gap cycle, then gnt_idx=2.
- MAX_HOLD=4, req=8'b1000_0001 held, no done:
  - gnt_idx=7 for exactly 4 cycles, then timeout=1 for one cycle with gnt_vld=0.
  - Next grant is gnt_idx=0 (mask excludes 7) in both builds.
- Owner 3 (req=8'b0000_1000) drops req mid-grant → gnt_vld=0 next cycle, timeout=0; with req=0 the arbiter stays IDLE.
- done and counter==MAX_HOLD-1 in the same cycle (MAX_HOLD=4, done at 4th grant cycle) → release with timeout=0; the same requester is eligible at the next arbitration.
- rst_n low mid-grant (gnt_idx=6) → gnt=0, gnt_vld=0, gnt_idx=0 immediately, without waiting for a clock edge.
  - After rst_n rises with req=8'b0100_0000 → gnt_idx=6 one cycle later, ROUND_ROBIN_EN ptr back to 0.
